// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the two-player scoreboard match controller.
package scoreboard_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned SCORE_MAX = 99;
    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned GAMES_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        PLAY      = 2'd0,
        GAME_WON  = 2'd1,
        MATCH_WON = 2'd2
    } state_t;

    // Add one point, holding at the display limit.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score);
        return (score >= SCORE_W'(SCORE_MAX)) ? score : score + 1'b1;
    endfunction

endpackage

// File: rtl/scoreboard_serve_tracker.sv
// Combinational server selection from the current points and the game's first server.
// Outside deuce the serve changes every SERVE_ROTATE points; in deuce it changes every point.
module scoreboard_serve_tracker
    import scoreboard_pkg::*;
#(
    parameter int unsigned POINTS_TO_WIN = 11,
    parameter int unsigned SERVE_ROTATE  = 2
) (
    input  logic [SCORE_W-1:0] p1_score,
    input  logic [SCORE_W-1:0] p2_score,
    input  logic               start_server,
    output logic               server
);

    localparam logic [SCORE_W-1:0] DEUCE_AT = SCORE_W'(POINTS_TO_WIN - 1);
    localparam logic [SCORE_W:0]   ROTATE   = (SCORE_W+1)'(SERVE_ROTATE);

    logic [SCORE_W:0] total;
    logic [SCORE_W:0] turn;
    logic             deuce;

    // Pick the server from the total points played and the deuce condition.
    always_comb begin
        total  = {1'b0, p1_score} + {1'b0, p2_score};
        turn   = total / ROTATE;
        deuce  = (p1_score >= DEUCE_AT) && (p2_score >= DEUCE_AT);
        server = deuce ? (start_server ^ total[0]) : (start_server ^ turn[0]);
    end

endmodule

// File: rtl/scoreboard_match_sequencer.sv
// Match-level controller: points, game wins, games count, win-display hold and server.
// Optional feature macro: SCOREBOARD_SERVE_TRACK_EN enables server tracking;
// when undefined server_o is constant 0.
module scoreboard_match_sequencer
    import scoreboard_pkg::*;
#(
    parameter int unsigned POINTS_TO_WIN = 11,
    parameter int unsigned WIN_BY        = 2,
    parameter int unsigned GAMES_TO_WIN  = 3,
    parameter logic [23:0] HOLD_CYCLES   = 24'd5_000_000,
    parameter int unsigned SERVE_ROTATE  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               p1_inc_i,
    input  logic               p2_inc_i,
    input  logic               p1_dec_i,
    input  logic               p2_dec_i,
    input  logic               new_match_i,
    output logic [SCORE_W-1:0] p1_score_o,
    output logic [SCORE_W-1:0] p2_score_o,
    output logic [GAMES_W-1:0] p1_games_o,
    output logic [GAMES_W-1:0] p2_games_o,
    output logic               server_o,
    output logic [STATE_W-1:0] state_o,
    output logic               game_won_o,
    output logic               winner_o
);

    localparam logic [SCORE_W-1:0]        TARGET    = SCORE_W'(POINTS_TO_WIN);
    localparam logic signed [SCORE_W:0]   LEAD      = (SCORE_W+1)'(WIN_BY);
    localparam logic [GAMES_W-1:0]        GAMES_TGT = GAMES_W'(GAMES_TO_WIN);
    localparam logic [23:0]               HOLD_LAST = HOLD_CYCLES - 24'd1;

    state_t             state, state_n;
    logic [SCORE_W-1:0] p1_q, p1_n, p2_q, p2_n;
    logic [GAMES_W-1:0] g1_q, g1_n, g2_q, g2_n;
    logic [23:0]        hold_q, hold_n;
    logic               gw_q, gw_n;
    logic               win_q, win_n;

    // True when 'own' has reached the target with the required lead over 'opp'.
    function automatic logic takes_game(input logic [SCORE_W-1:0] own,
                                        input logic [SCORE_W-1:0] opp);
        logic signed [SCORE_W:0] diff;
        diff = $signed({1'b0, own}) - $signed({1'b0, opp});
        return (own >= TARGET) && (diff >= LEAD);
    endfunction

`ifdef SCOREBOARD_SERVE_TRACK_EN
    logic ss_q, ss_n;
    logic srv_q, srv_n;

    scoreboard_serve_tracker #(
        .POINTS_TO_WIN (POINTS_TO_WIN),
        .SERVE_ROTATE  (SERVE_ROTATE)
    ) u_serve (
        .p1_score     (p1_n),
        .p2_score     (p2_n),
        .start_server (ss_n),
        .server       (srv_n)
    );

    assign server_o = srv_q;
`else
    assign server_o = 1'b0;
`endif

    // Next-state and next-value logic; new_match_i overrides every other action.
    always_comb begin
        state_n = state;
        p1_n    = p1_q;
        p2_n    = p2_q;
        g1_n    = g1_q;
        g2_n    = g2_q;
        hold_n  = hold_q;
        gw_n    = 1'b0;
        win_n   = win_q;
`ifdef SCOREBOARD_SERVE_TRACK_EN
        ss_n    = ss_q;
`endif
        if (new_match_i) begin
            state_n = PLAY;
            p1_n    = '0;
            p2_n    = '0;
            g1_n    = '0;
            g2_n    = '0;
            hold_n  = '0;
            win_n   = 1'b0;
`ifdef SCOREBOARD_SERVE_TRACK_EN
            ss_n    = 1'b0;
`endif
        end else begin
            unique case (state)
                PLAY: begin
                    if (p1_inc_i) begin
                        p1_n = sat_inc(p1_q);
                        if (takes_game(p1_n, p2_q)) begin
                            g1_n    = g1_q + 1'b1;
                            win_n   = 1'b0;
                            gw_n    = 1'b1;
                            hold_n  = '0;
                            state_n = (g1_n == GAMES_TGT) ? MATCH_WON : GAME_WON;
                        end
                    end else if (p2_inc_i) begin
                        p2_n = sat_inc(p2_q);
                        if (takes_game(p2_n, p1_q)) begin
                            g2_n    = g2_q + 1'b1;
                            win_n   = 1'b1;
                            gw_n    = 1'b1;
                            hold_n  = '0;
                            state_n = (g2_n == GAMES_TGT) ? MATCH_WON : GAME_WON;
                        end
                    end else if (p1_dec_i) begin
                        if (p1_q != '0) p1_n = p1_q - 1'b1;
                    end else if (p2_dec_i) begin
                        if (p2_q != '0) p2_n = p2_q - 1'b1;
                    end
                end
                GAME_WON: begin
                    if (hold_q == HOLD_LAST) begin
                        p1_n    = '0;
                        p2_n    = '0;
                        hold_n  = '0;
                        state_n = PLAY;
`ifdef SCOREBOARD_SERVE_TRACK_EN
                        ss_n    = ~ss_q;
`endif
                    end else begin
                        hold_n = hold_q + 24'd1;
                    end
                end
                MATCH_WON: begin
                    state_n = MATCH_WON;
                end
                default: begin
                    state_n = PLAY;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= PLAY;
            p1_q   <= '0;
            p2_q   <= '0;
            g1_q   <= '0;
            g2_q   <= '0;
            hold_q <= '0;
            gw_q   <= 1'b0;
            win_q  <= 1'b0;
`ifdef SCOREBOARD_SERVE_TRACK_EN
            ss_q   <= 1'b0;
            srv_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            p1_q   <= p1_n;
            p2_q   <= p2_n;
            g1_q   <= g1_n;
            g2_q   <= g2_n;
            hold_q <= hold_n;
            gw_q   <= gw_n;
            win_q  <= win_n;
`ifdef SCOREBOARD_SERVE_TRACK_EN
            ss_q   <= ss_n;
            srv_q  <= srv_n;
`endif
        end
    end

    assign p1_score_o = p1_q;
    assign p2_score_o = p2_q;
    assign p1_games_o = g1_q;
    assign p2_games_o = g2_q;
    assign state_o    = state;
    assign game_won_o = gw_q;
    assign winner_o   = win_q;

endmodule

// File: tb/tb_scoreboard_match_sequencer.sv
// Self-checking bench: directed scenarios plus random pulses against a behavioural match model.
module tb_scoreboard_match_sequencer;

    localparam int P   = 11;
    localparam int WB  = 2;
    localparam int GT  = 2;
    localparam int H   = 4;
    localparam int ROT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i1 = 1'b0, i2 = 1'b0, d1 = 1'b0, d2 = 1'b0, nm = 1'b0;
    logic [7:0] p1_score, p2_score;
    logic [3:0] p1_games, p2_games;
    logic       server, game_won, winner;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Model: phase 0=play, 1=showing game result, 2=match over.
    int m_s1 = 0, m_s2 = 0, m_g1 = 0, m_g2 = 0, m_phase = 0, m_left = 0;
    int m_first = 0, m_win = 0, m_gw = 0;

    always #5 clk = ~clk;

    scoreboard_match_sequencer #(
        .POINTS_TO_WIN (P),
        .WIN_BY        (WB),
        .GAMES_TO_WIN  (GT),
        .HOLD_CYCLES   (24'(H)),
        .SERVE_ROTATE  (ROT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .p1_inc_i    (i1),
        .p2_inc_i    (i2),
        .p1_dec_i    (d1),
        .p2_dec_i    (d2),
        .new_match_i (nm),
        .p1_score_o  (p1_score),
        .p2_score_o  (p2_score),
        .p1_games_o  (p1_games),
        .p2_games_o  (p2_games),
        .server_o    (server),
        .state_o     (state),
        .game_won_o  (game_won),
        .winner_o    (winner)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_server();
`ifdef SCOREBOARD_SERVE_TRACK_EN
        int t;
        t = m_s1 + m_s2;
        if (m_s1 >= P - 1 && m_s2 >= P - 1) return m_first ^ (t % 2);
        return m_first ^ ((t / ROT) % 2);
`else
        return 0;
`endif
    endfunction

    task automatic award(input int who);
        if (who == 0) m_g1++; else m_g2++;
        m_win = who;
        m_gw  = 1;
        m_phase = (((who == 0) ? m_g1 : m_g2) == GT) ? 2 : 1;
        m_left  = H;
    endtask

    task automatic model_step(input bit a1, input bit a2, input bit s1, input bit s2,
                              input bit newm, input bit r);
        m_gw = 0;
        if (r || newm) begin
            m_s1 = 0; m_s2 = 0; m_g1 = 0; m_g2 = 0;
            m_phase = 0; m_first = 0; m_win = 0;
        end else if (m_phase == 0) begin
            if (a1) begin
                if (m_s1 < 99) m_s1++;
                if (m_s1 >= P && m_s1 - m_s2 >= WB) award(0);
            end else if (a2) begin
                if (m_s2 < 99) m_s2++;
                if (m_s2 >= P && m_s2 - m_s1 >= WB) award(1);
            end else if (s1) begin
                if (m_s1 > 0) m_s1--;
            end else if (s2) begin
                if (m_s2 > 0) m_s2--;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_s1 = 0; m_s2 = 0;
                m_first = 1 - m_first;
                m_phase = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("p1_score", p1_score, m_s1);
        check("p2_score", p2_score, m_s2);
        check("p1_games", p1_games, m_g1);
        check("p2_games", p2_games, m_g2);
        check("state",    state,    m_phase);
        check("game_won", game_won, m_gw);
        check("winner",   winner,   m_win);
        check("server",   server,   exp_server());
    endtask

    // One clock: drive pulses, let the edge happen, advance the model, compare.
    task automatic cycle(input bit a1, input bit a2, input bit s1, input bit s2,
                         input bit newm, input bit r);
        @(negedge clk);
        i1 = a1; i2 = a2; d1 = s1; d2 = s2; nm = newm; rst = r;
        @(posedge clk);
        model_step(a1, a2, s1, s2, newm, r);
        #1;
        compare_all();
        i1 = 0; i2 = 0; d1 = 0; d2 = 0; nm = 0; rst = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("reset_state", state, 0);
        check("reset_p1", p1_score, 0);
        check("reset_server", server, 0);

        // First game: eleven straight points for player 1.
        for (int k = 0; k < 11; k++) cycle(1, 0, 0, 0, 0, 0);
        check("g1_p1_score", p1_score, 11);
        check("g1_games", p1_games, 1);
        check("g1_pulse", game_won, 1);
        check("g1_state", state, 1);
        idle(1);
        check("g1_pulse_once", game_won, 0);
        idle(3);
        check("g1_clear", p1_score, 0);
        check("g1_play", state, 0);
`ifdef SCOREBOARD_SERVE_TRACK_EN
        check("g1_server", server, 1);
`else
        check("g1_server", server, 0);
`endif

        // Deuce: 10-10, 11-10, 11-11, then two points to 13-11 ends the match.
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            cycle(0, 1, 0, 0, 0, 0);
        end
        cycle(1, 0, 0, 0, 0, 0);
        check("deuce_no_win", state, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check("deuce_p1", p1_score, 13);
        check("match_state", state, 2);
        check("match_winner", winner, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("match_frozen", p2_score, 11);
        cycle(1, 1, 0, 0, 1, 0);
        check("new_match_games", p1_games, 0);
        check("new_match_state", state, 0);

        // Priority, dec at zero, and pulses ignored while showing a result.
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 0, 0, 0, 0);
            cycle(0, 1, 0, 0, 0, 0);
        end
        cycle(1, 1, 1, 1, 0, 0);
        check("prio_p1", p1_score, 4);
        check("prio_p2", p2_score, 3);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check("dec_at_zero", p2_score, 0);
        for (int k = 0; k < 11; k++) cycle(0, 1, 0, 0, 0, 0);
        check("p2_game_winner", winner, 1);
        cycle(1, 1, 1, 1, 0, 0);
        check("hold_ignores_p1", p1_score, 0);
        check("hold_ignores_p2", p2_score, 11);

        // Reset while the result is being shown.
        cycle(0, 0, 0, 0, 0, 1);
        check("rst_hold_state", state, 0);
        check("rst_hold_games", p2_games, 0);
        for (int k = 0; k < 11; k++) cycle(1, 0, 0, 0, 0, 0);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1);
        check("rst_mid_state", state, 0);
        check("rst_mid_score", p1_score, 0);

        // Random pulse traffic.
        for (int k = 0; k < 4000; k++) begin
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 299) == 0, $urandom_range(0, 799) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scoreboard_match_sequencer.md
# scoreboard_match_sequencer

Match-level controller for the two-player scoreboard. It owns both point registers and applies the single-cycle short-press and long-press pulses from the per-player long-press detectors. It decides game wins by target score plus required lead, counts games won, and sequences a timed win-display phase before clearing points for the next game. It also tracks which player serves and drives all score and status values to the display path.

## Interface
- POINTS_TO_WIN, 11, points needed to win a game (1..99)
- WIN_BY, 2, required lead over the opponent at game win (1..9)
- GAMES_TO_WIN, 3, games needed to win the match (1..15)
- HOLD_CYCLES, 24'd5_000_000, length of the GAME_WON display phase in clock cycles (≥1)
- SERVE_ROTATE, 2, points per serve turn outside deuce (≥1)
- clk_i  in  1  system clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- p1_inc_i / p2_inc_i  in  1  single-cycle add-point pulse (short press)
- p1_dec_i / p2_dec_i  in  1  single-cycle remove-point pulse (long press)
- new_match_i  in  1  single-cycle pulse; restarts the match
- p1_score_o / p2_score_o  out  8  current game points, 0..99
- p1_games_o / p2_games_o  out  4  games won
- server_o  out  1  0 = player 1 serves, 1 = player 2 serves
- state_o  out  2  FSM state: PLAY=0, GAME_WON=1, MATCH_WON=2
- game_won_o  out  1  one-cycle pulse when a game is decided
- winner_o  out  1  winner of the most recent game/match (0 = P1, 1 = P2)

## Operation
- Reset values:
  - Scores, games and hold counter = 0.
  - state_o = PLAY.
  - server_o = 0, start_server = 0.
  - game_won_o = 0, winner_o = 0.
- **PLAY**
  - Priority per cycle: p1_inc > p2_inc > p1_dec > p2_dec. Exactly one action is applied; lower-priority pulses in the same cycle are dropped.
  - inc saturates at 99. dec at 0 is a no-op.
  - After an inc, a player with score ≥ POINTS_TO_WIN and score − opponent ≥ WIN_BY wins the game. A dec never wins a game.
  - On a game win:
    - The winner's games counter increments and winner_o is set to that player.
    - game_won_o pulses.
    - If the new games count equals GAMES_TO_WIN, the FSM goes to MATCH_WON; otherwise it goes to GAME_WON.
- **GAME_WON**
  - All inc/dec pulses are ignored. The final points stay visible.
  - The hold counter counts up to HOLD_CYCLES−1. On the next cycle:
    - Points clear to 0.
    - start_server toggles.
    - The FSM returns to PLAY.
- **MATCH_WON**
  - Scores and games are frozen and inc/dec pulses are ignored.
  - Only new_match_i or rst_i leaves this state.
- new_match_i in any state clears scores, games, hold counter and start_server, sets winner_o = 0, and enters PLAY. It overrides any inc/dec pulse in the same cycle.
- Server rule, with t = p1_score + p2_score:
  - Deuce means both scores ≥ POINTS_TO_WIN−1. In deuce, server = start_server XOR t[0].
  - Otherwise, server = start_server XOR ((t / SERVE_ROTATE) mod 2).
- Arithmetic:
  - The lead comparison uses 9-bit signed difference.
  - Games counters are 4-bit and cannot exceed GAMES_TO_WIN.

## Timing
- All outputs are registered.
- A pulse sampled at edge N updates score/server at N+1. In the same cycle, state_o, games and game_won_o reflect a win.
- GAME_WON lasts exactly HOLD_CYCLES cycles. Points read 0 in the cycle after the last hold cycle.
- rst_i asserted mid-game or mid-hold returns all outputs to reset values at the next edge.

## Configuration
- SCOREBOARD_SERVE_TRACK_EN:
  - Defined: server logic, start_server toggling and the deuce rule are compiled in.
  - Undefined: server_o is tied 0, start_server is removed, and SERVE_ROTATE is unused.
  - All other behaviour is identical in both builds.

## Structure
- Shared package scoreboard_pkg holds:
  - the state enum (PLAY/GAME_WON/MATCH_WON) and its 2-bit width;
  - SCORE_MAX = 99, SCORE_W = 8, GAMES_W = 4.
- One sub-module: scoreboard_serve_tracker. It is combinational from scores, start_server and parameters to server, and is instantiated only under SCOREBOARD_SERVE_TRACK_EN.

## Test plan
All scenarios use POINTS_TO_WIN=11, WIN_BY=2, GAMES_TO_WIN=2 and HOLD_CYCLES=4.
- 11 p1_inc pulses from 0–0 → on the 11th: p1_score=11, p1_games=1, game_won_o=1 for one cycle, state=GAME_WON. 4 cycles later: scores 0–0, state=PLAY, server=1.
- Deuce: reach 10–10, then p1_inc → 11–10, no win. Then p2_inc → 11–11. Then p1_inc ×2 → win at 13–11. server alternates on every point from 10–10.
- Same-cycle p1_inc and p2_inc at 3–3 → 4–3. p2 dec at 0 → stays 0. Inc pulses during GAME_WON → ignored.
- P1 wins two games → state=MATCH_WON, winner_o=0. Further incs are ignored. new_match_i → all zero, state=PLAY.
- rst_i asserted during the GAME_WON hold (cycle 2) → next edge: all outputs at reset values, state=PLAY.
- Build without SCOREBOARD_SERVE_TRACK_EN, run the first scenario → identical scores, server_o constant 0.
